// File: rtl/spi_arb_pkg.sv
// Shared types and helpers for the SPI chip-select arbiter.
// State encoding, chip-select idle level and the counter-width helper live here.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StRun   = 3'd2,
    StFin   = 3'd3,
    StAbort = 3'd4
  } arb_state_e;

  localparam logic CsIdle = 1'b1;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(n)) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request scanning from ptr upward,
// wrapping to index 0. Produces a one-hot grant and the matching index.
module rr_pick
  import spi_arb_pkg::*;
#(
  parameter int unsigned NReq = 2,
  parameter int unsigned PtrW = 1
) (
  input  logic [NReq-1:0] req_i,
  input  logic [PtrW-1:0] ptr_i,
  output logic [NReq-1:0] grant_o,
  output logic [PtrW-1:0] index_o,
  output logic            valid_o
);

  always_comb begin
    grant_o = '0;
    index_o = '0;
    valid_o = 1'b0;
    // Lowest requester overall is the wrap-around fallback.
    for (int i = NReq - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        index_o = PtrW'(i);
      end
    end
    // Lowest requester at or above ptr overrides the fallback.
    for (int i = NReq - 1; i >= 0; i--) begin
      if (req_i[i] && (PtrW'(i) >= ptr_i)) begin
        index_o = PtrW'(i);
      end
    end
    for (int i = 0; i < NReq; i++) begin
      grant_o[i] = valid_o && (index_o == PtrW'(i));
    end
  end

endmodule

// File: rtl/spi_cs_arbiter.sv
// Round-robin arbiter and handshake sequencer in front of one shared SPI_Out shift engine.
// Grants one requester at a time, runs RST+EN / WAIT-high / WAIT-low, steers CS to its line.
module spi_cs_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [N_REQ-1:0]   REQ,
  input  logic [8*N_REQ-1:0] DATA_IN,
  output logic [N_REQ-1:0]   GRANT,
  output logic [N_REQ-1:0]   DONE,
  output logic               ERR,
  output logic               BUSY,
  output logic               SPI_EN,
  output logic               SPI_RST,
  output logic [7:0]         SPI_DATA,
  input  logic               SPI_WAIT,
  input  logic               SPI_CS,
  output logic [N_REQ-1:0]   CS_OUT
);

  localparam int unsigned PtrW = cnt_width(N_REQ);
  localparam int unsigned WdW  = cnt_width(TIMEOUT);
  localparam logic [PtrW-1:0] LastIdx  = PtrW'(N_REQ - 1);
  localparam logic [WdW-1:0]  WdogLast = WdW'(TIMEOUT - 1);

  arb_state_e       state_q, state_d;
  logic [PtrW-1:0]  ptr_q, ptr_d;
  logic [PtrW-1:0]  idx_q, idx_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             spi_en_q, spi_en_d;
  logic             spi_rst_q, spi_rst_d;
  logic [7:0]       data_q, data_d;
  logic [WdW-1:0]   wdog_q, wdog_d;

  logic [N_REQ-1:0] pick_grant;
  logic [PtrW-1:0]  pick_idx;
  logic             pick_valid;
  logic [PtrW-1:0]  ptr_next;

  rr_pick #(
    .NReq (N_REQ),
    .PtrW (PtrW)
  ) u_rr_pick (
    .req_i   (REQ),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .index_o (pick_idx),
    .valid_o (pick_valid)
  );

  assign ptr_next = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    grant_d   = grant_q;
    done_d    = '0;
    err_d     = 1'b0;
    spi_en_d  = spi_en_q;
    spi_rst_d = spi_rst_q;
    data_d    = data_q;
    wdog_d    = wdog_q;

    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          idx_d     = pick_idx;
          grant_d   = pick_grant;
          spi_en_d  = 1'b1;
          spi_rst_d = 1'b1;
          wdog_d    = '0;
          state_d   = StStart;
          for (int i = 0; i < N_REQ; i++) begin
            if (pick_grant[i]) begin
              data_d = DATA_IN[8*i +: 8];
            end
          end
        end
      end

      StStart, StRun: begin
        if (wdog_q == WdogLast) begin
          // Engine never finished: pulse its reset instead of completing.
          spi_en_d  = 1'b0;
          spi_rst_d = 1'b1;
          err_d     = 1'b1;
          state_d   = StAbort;
        end else begin
          wdog_d = wdog_q + 1'b1;
          if (state_q == StStart) begin
            if (SPI_WAIT) begin
              spi_rst_d = 1'b0;
              state_d   = StRun;
            end
          end else if (!SPI_WAIT) begin
            spi_en_d = 1'b0;
            done_d   = grant_q;
            state_d  = StFin;
          end
        end
      end

      StFin: begin
        grant_d = '0;
        ptr_d   = ptr_next;
        state_d = StIdle;
      end

      StAbort: begin
        grant_d   = '0;
        spi_rst_d = 1'b0;
        ptr_d     = ptr_next;
        state_d   = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      idx_q     <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      spi_en_q  <= 1'b0;
      spi_rst_q <= 1'b0;
      data_q    <= '0;
      wdog_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      spi_en_q  <= spi_en_d;
      spi_rst_q <= spi_rst_d;
      data_q    <= data_d;
      wdog_q    <= wdog_d;
    end
  end

  // Only the granted line follows the engine CS; reset forces all lines idle at once.
  always_comb begin
    CS_OUT = {N_REQ{CsIdle}};
    if (!RST && ((state_q == StStart) || (state_q == StRun))) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (grant_q[i]) begin
          CS_OUT[i] = SPI_CS;
        end
      end
    end
  end

  assign GRANT    = grant_q;
  assign DONE     = done_q;
  assign ERR      = err_q;
  assign BUSY     = busy_q;
  assign SPI_EN   = spi_en_q;
  assign SPI_RST  = spi_rst_q;
  assign SPI_DATA = data_q;

endmodule

// File: tb/tb_spi_cs_arbiter.sv
// Bench for spi_cs_arbiter: behavioural SPI_Out engine, transaction-level round-robin
// reference model, directed scenarios followed by randomized requester traffic.
module tb_spi_cs_arbiter;

  localparam int unsigned NReq  = 2;
  localparam int unsigned Tmo   = 16;
  localparam int unsigned Never = 32'hFFFF_FFFF;

  logic              CLK = 1'b0;
  logic              RST;
  logic [NReq-1:0]   REQ;
  logic [8*NReq-1:0] DATA_IN;
  logic [NReq-1:0]   GRANT, DONE, CS_OUT;
  logic              ERR, BUSY, SPI_EN, SPI_RST, SPI_WAIT, SPI_CS;
  logic [7:0]        SPI_DATA;

  spi_cs_arbiter #(
    .N_REQ   (NReq),
    .TIMEOUT (Tmo)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .REQ      (REQ),
    .DATA_IN  (DATA_IN),
    .GRANT    (GRANT),
    .DONE     (DONE),
    .ERR      (ERR),
    .BUSY     (BUSY),
    .SPI_EN   (SPI_EN),
    .SPI_RST  (SPI_RST),
    .SPI_DATA (SPI_DATA),
    .SPI_WAIT (SPI_WAIT),
    .SPI_CS   (SPI_CS),
    .CS_OUT   (CS_OUT)
  );

  always #5 CLK = ~CLK;

  int unsigned n_vec, n_bad, cyc;

  // Reference model: who is being served, and when each event is due.
  bit          act, dead;
  int unsigned w, ptr_m, start_cyc, rise_cyc, done_cyc, err_cyc, free_at;
  logic [7:0]  exp_data;
  bit          done_now, err_now, grant_now;
  int unsigned last_idx;
  logic [NReq-1:0] svc_q[$];

  // Engine model: 0 idle, 1 delay before WAIT, 2 shifting, 3 finished.
  int unsigned e_phase, e_cnt;
  logic [7:0]  e_byte;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int unsigned pick(input logic [NReq-1:0] r, input int unsigned p);
    for (int k = 0; k < NReq; k++) begin
      int unsigned i;
      i = (p + k) % NReq;
      if (((r >> i) & 1) != 0) return i;
    end
    return 0;
  endfunction

  task automatic tick();
    logic [NReq-1:0]   r;
    logic [8*NReq-1:0] dat;
    logic              rs;
    logic [NReq-1:0]   cs_exp;
    r   = REQ;
    dat = DATA_IN;
    rs  = RST;
    @(posedge CLK);
    #1;
    cyc++;
    done_now  = 0;
    err_now   = 0;
    grant_now = 0;

    if (rs) begin
      chk("rst_outs", {GRANT, DONE, ERR, BUSY, SPI_EN, SPI_RST}, 0);
      chk("rst_data", SPI_DATA, 8'h00);
      chk("rst_cs_out", CS_OUT, {NReq{1'b1}});
      act      = 0;
      ptr_m    = 0;
      free_at  = cyc + 1;
      e_phase  = 0;
      SPI_WAIT = 1'b0;
      SPI_CS   = 1'b1;
      return;
    end

    cs_exp = {NReq{1'b1}};
    if (act && !SPI_CS) cs_exp[w] = 1'b0;
    chk("cs_out", CS_OUT, cs_exp);

    if (!act && cyc >= free_at && r != 0) begin
      w         = pick(r, ptr_m);
      exp_data  = dat[8*w +: 8];
      act       = 1;
      start_cyc = cyc;
      rise_cyc  = Never;
      done_cyc  = Never;
      err_cyc   = dead ? cyc + Tmo : Never;
      grant_now = 1;
      svc_q.push_back(GRANT);
    end

    if (act) begin
      chk("grant", GRANT, 1 << w);
      chk("spi_data", SPI_DATA, exp_data);
      chk("busy", BUSY, 1);
      chk("done", DONE, (cyc == done_cyc) ? (1 << w) : 0);
      chk("err", ERR, cyc == err_cyc);
      if (cyc == err_cyc) begin
        chk("abort_en", SPI_EN, 0);
        chk("abort_rst", SPI_RST, 1);
        act = 0; err_now = 1; last_idx = w;
        ptr_m = (w + 1) % NReq; free_at = cyc + 2;
      end else if (cyc == done_cyc) begin
        chk("fin_en", SPI_EN, 0);
        chk("shifted_byte", e_byte, exp_data);
        act = 0; done_now = 1; last_idx = w;
        ptr_m = (w + 1) % NReq; free_at = cyc + 2;
      end else begin
        chk("xfer_en", SPI_EN, 1);
        chk("xfer_rst", SPI_RST, cyc <= rise_cyc);
      end
    end else begin
      chk("idle_outs", {GRANT, DONE, ERR, BUSY, SPI_EN, SPI_RST}, 0);
    end

    if (SPI_RST && !SPI_EN) begin
      e_phase = 0; SPI_WAIT = 1'b0; SPI_CS = 1'b1;
    end else begin
      case (e_phase)
        0: if (SPI_EN && SPI_RST) begin e_phase = 1; e_cnt = $urandom_range(6, 1); end
        1: if (!dead) begin
          e_cnt--;
          if (e_cnt == 0) begin
            e_phase = 2; SPI_WAIT = 1'b1; SPI_CS = 1'b0;
            e_byte = SPI_DATA; rise_cyc = cyc; e_cnt = $urandom_range(7, 1);
          end
        end
        2: begin
          e_cnt--;
          if (e_cnt == 0) begin
            e_phase = 3; SPI_WAIT = 1'b0; SPI_CS = 1'b1; done_cyc = cyc + 1;
          end
        end
        default: if (!SPI_EN) e_phase = 0;
      endcase
    end
  endtask

  // kind: 0 done, 1 err, 2 grant, 3 engine shifting.
  task automatic run_until(input int kind, input int unsigned limit);
    int unsigned n;
    bit hit;
    n = 0;
    hit = 0;
    while (!hit && n < limit) begin
      tick();
      n++;
      case (kind)
        0:       hit = done_now;
        1:       hit = err_now;
        2:       hit = grant_now;
        default: hit = (e_phase == 2);
      endcase
    end
    chk($sformatf("wait_kind%0d", kind), {31'd0, hit}, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed no finish, required finish");
    $fatal(1);
  end

  initial begin
    n_vec = 0; n_bad = 0; cyc = 0;
    act = 0; dead = 0; ptr_m = 0; free_at = 0; e_phase = 0; e_cnt = 0;
    RST = 1'b1; REQ = '0; DATA_IN = '0; SPI_WAIT = 1'b0; SPI_CS = 1'b1;
    tick(); tick();
    RST = 1'b0;
    tick();

    // Single request from slot 0.
    DATA_IN[7:0] = 8'hA5; REQ = 2'b01;
    run_until(2, 1);
    run_until(0, 40);
    REQ = '0;
    tick(); tick();

    // Contention from ptr 0: service must alternate.
    RST = 1'b1; tick(); RST = 1'b0;
    svc_q.delete();
    REQ = 2'b11;
    repeat (4) run_until(0, 40);
    REQ = '0;
    chk("t2_count", svc_q.size(), 4);
    for (int i = 0; i < 4 && i < svc_q.size(); i++) chk("t2_order", svc_q[i], (i % 2 == 0) ? 1 : 2);
    tick(); tick();

    // Data changed right after grant must not reach the engine.
    DATA_IN[7:0] = 8'h3C; REQ = 2'b01;
    run_until(2, 4);
    DATA_IN[7:0] = 8'hFF;
    run_until(0, 40);
    chk("t6_latch", SPI_DATA, 8'h3C);
    REQ = '0;
    tick(); tick();

    // Granted requester drops mid-transfer; the other one queues up.
    svc_q.delete();
    REQ = 2'b01;
    run_until(2, 4);
    REQ[1] = 1'b1;
    run_until(3, 20);
    REQ[0] = 1'b0;
    run_until(0, 40);
    run_until(2, 4);
    chk("t5_next_grant", (svc_q.size() > 1) ? svc_q[1] : 0, 2'b10);
    run_until(0, 40);
    REQ = '0;
    tick(); tick();

    // Engine never raises WAIT: watchdog abort.
    dead = 1; REQ = 2'b01;
    run_until(1, 40);
    dead = 0; REQ = '0;
    tick(); tick();

    // Reset while shifting.
    REQ = 2'b01;
    run_until(2, 4);
    run_until(3, 20);
    tick();
    RST = 1'b1;
    #1;
    chk("t4_cs_same_cycle", CS_OUT, {NReq{1'b1}});
    tick();
    RST = 1'b0;
    svc_q.delete();
    REQ = 2'b11;
    run_until(2, 4);
    chk("t4_ptr_reset", (svc_q.size() > 0) ? svc_q[0] : 0, 2'b01);
    run_until(0, 40);
    REQ = '0;
    tick(); tick();

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      tick();
      if (done_now) REQ[last_idx] = 1'b0;
      if (err_now) dead = 0;
      if (act && $urandom_range(15, 0) == 0) REQ[w] = 1'b0;
      for (int i = 0; i < NReq; i++) begin
        if (!REQ[i] && $urandom_range(3, 0) == 0) begin
          REQ[i] = 1'b1;
          DATA_IN[8*i +: 8] = 8'($urandom);
        end
        if ($urandom_range(7, 0) == 0) DATA_IN[8*i +: 8] = 8'($urandom);
      end
      if (!act && !dead && $urandom_range(39, 0) == 0) dead = 1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
